// File: rtl/score_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : score_timer_ctrl
// Description : HUD game-round controller. Sequences a round (start,
//               per-second countdown, time-out, end-of-level bonus), owns the
//               packed-BCD score and time-left counters, arbitrates point-add
//               requests and serves registered ASCII digits to the text path.
// Revision    : 1.0 - initial release
// ============================================================================
module score_timer_ctrl #(
    parameter int         CLK_HZ     = 65_000_000,
    parameter logic [7:0] TIME_START = 8'h99
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pause,
    input  logic        level_done,
    input  logic        add_req,
    input  logic [3:0]  add_val,
    output logic        add_ack,
    input  logic [7:0]  char_xy,
    output logic [6:0]  char_code,
    output logic        char_hit,
    output logic [15:0] score_bcd,
    output logic [7:0]  time_bcd,
    output logic        time_up,
    output logic [2:0]  state
);

    // A 1 Hz tick needs at least one bit even for degenerate CLK_HZ values.
    localparam int               c_TW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_TW-1:0]  c_TICK_MAX  = c_TW'(CLK_HZ - 1);
    localparam logic [c_TW-1:0]  c_TICK_ONE  = c_TW'(1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_RUN   = 3'd1;
    localparam logic [2:0] c_ST_BONUS = 3'd2;
    localparam logic [2:0] c_ST_DONE  = 3'd3;
    localparam logic [2:0] c_ST_OVER  = 3'd4;

    logic [2:0]      r_state;
    logic [15:0]     r_score;
    logic [7:0]      r_time;
    logic [c_TW-1:0] r_tick;
    logic            r_add_ack;
    logic [6:0]      r_char_code;
    logic            r_char_hit;

    logic            w_add_take;
    logic [3:0]      w_add_val;
    logic            w_tick_wrap;
    logic [3:0]      w_digit;
    logic            w_hit;

    // 4-digit BCD add of a single decimal digit; any carry out of the
    // thousands digit pins the result at 9999.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] s, input logic [3:0] v);
        logic [15:0] res;
        logic [4:0]  acc;
        logic [4:0]  adj;
        logic [3:0]  cin;
        res = 16'h0000;
        cin = v;
        for (int i = 0; i < 4; i++) begin
            acc = {1'b0, s[4*i +: 4]} + {1'b0, cin};
            if (acc > 5'd9) begin
                adj            = acc - 5'd10;
                res[4*i +: 4]  = adj[3:0];
                cin            = 4'd1;
            end else begin
                res[4*i +: 4]  = acc[3:0];
                cin            = 4'd0;
            end
        end
        if (cin != 4'd0) begin
            res = 16'h9999;
        end
        return res;
    endfunction

    // 2-digit BCD decrement; callers never pass 00.
    function automatic logic [7:0] bcd_dec2(input logic [7:0] t);
        if (t[3:0] == 4'd0) begin
            return {t[7:4] - 4'd1, 4'd9};
        end
        return {t[7:4], t[3:0] - 4'd1};
    endfunction

    // A request is taken only while no ack is outstanding, so a request
    // still held during its ack cycle is not counted twice.
    assign w_add_take  = add_req & ~r_add_ack;
    assign w_add_val   = (add_val > 4'd9) ? 4'd9 : add_val;
    assign w_tick_wrap = (r_tick == c_TICK_MAX);

    // Round sequencing, countdown, bonus transfer and score updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_score   <= 16'h0000;
            r_time    <= 8'h00;
            r_tick    <= '0;
            r_add_ack <= 1'b0;
        end else begin
            r_add_ack <= w_add_take;
            case (r_state)
                c_ST_IDLE, c_ST_OVER: begin
                    if (start) begin
                        r_state <= c_ST_RUN;
                        r_score <= 16'h0000;
                        r_time  <= TIME_START;
                        r_tick  <= '0;
                    end
                end
                c_ST_DONE: begin
                    if (start) begin
                        r_state <= c_ST_RUN;
                        r_time  <= TIME_START;
                        r_tick  <= '0;
                    end
                end
                c_ST_RUN: begin
                    if (w_add_take) begin
                        r_score <= bcd_add_sat(r_score, w_add_val);
                    end
                    if (level_done) begin
                        // A coinciding second tick is dropped.
                        r_state <= c_ST_BONUS;
                        r_tick  <= '0;
                    end else if (!pause) begin
                        if (w_tick_wrap) begin
                            r_tick <= '0;
                            if (r_time != 8'h00) begin
                                r_time <= bcd_dec2(r_time);
                            end
                            if (r_time <= 8'h01) begin
                                r_state <= c_ST_OVER;
                            end
                        end else begin
                            r_tick <= r_tick + c_TICK_ONE;
                        end
                    end
                end
                c_ST_BONUS: begin
                    if (r_time != 8'h00) begin
                        r_time  <= bcd_dec2(r_time);
                        r_score <= bcd_add_sat(r_score, 4'd1);
                        if (r_time == 8'h01) begin
                            r_state <= c_ST_DONE;
                        end
                    end else begin
                        r_state <= c_ST_DONE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Select the digit for the numeric HUD fields addressed by char_xy.
    always_comb begin
        w_digit = 4'd0;
        w_hit   = 1'b1;
        case (char_xy)
            8'h07:   w_digit = r_score[15:12];
            8'h08:   w_digit = r_score[11:8];
            8'h09:   w_digit = r_score[7:4];
            8'h0A:   w_digit = r_score[3:0];
            8'h1A:   w_digit = r_time[7:4];
            8'h1B:   w_digit = r_time[3:0];
            default: w_hit   = 1'b0;
        endcase
    end

    // Register the ASCII code so it lines up with the font-ROM fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_char_code <= 7'h00;
            r_char_hit  <= 1'b0;
        end else begin
            r_char_code <= w_hit ? (7'h30 + {3'b000, w_digit}) : 7'h00;
            r_char_hit  <= w_hit;
        end
    end

    assign add_ack   = r_add_ack;
    assign char_code = r_char_code;
    assign char_hit  = r_char_hit;
    assign score_bcd = r_score;
    assign time_bcd  = r_time;
    assign time_up   = (r_state == c_ST_OVER);
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_score_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_timer_ctrl
// Description : Directed self-checking bench for score_timer_ctrl with a
//               4-cycle game second and a 12-second round.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_timer_ctrl;

    localparam int         c_CLK_HZ     = 4;
    localparam logic [7:0] c_TIME_START = 8'h12;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        pause;
    logic        level_done;
    logic        add_req;
    logic [3:0]  add_val;
    logic        add_ack;
    logic [7:0]  char_xy;
    logic [6:0]  char_code;
    logic        char_hit;
    logic [15:0] score_bcd;
    logic [7:0]  time_bcd;
    logic        time_up;
    logic [2:0]  state;

    int n_checks;
    int n_errors;

    score_timer_ctrl #(
        .CLK_HZ     (c_CLK_HZ),
        .TIME_START (c_TIME_START)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pause      (pause),
        .level_done (level_done),
        .add_req    (add_req),
        .add_val    (add_val),
        .add_ack    (add_ack),
        .char_xy    (char_xy),
        .char_code  (char_code),
        .char_hit   (char_hit),
        .score_bcd  (score_bcd),
        .time_bcd   (time_bcd),
        .time_up    (time_up),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One request, dropped after its first sampling edge.
    task automatic do_add(input logic [3:0] v);
        add_req = 1'b1;
        add_val = v;
        wait_cyc(1);
        add_req = 1'b0;
        wait_cyc(1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        wait_cyc(1);
        start = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        pause      = 1'b0;
        level_done = 1'b0;
        add_req    = 1'b0;
        add_val    = 4'd0;
        char_xy    = 8'h00;

        // Reset values.
        wait_cyc(2);
        check("rst_state", 32'(state), 32'd0);
        check("rst_score", 32'(score_bcd), 32'h0000);
        check("rst_time", 32'(time_bcd), 32'h00);
        check("rst_timeup", 32'(time_up), 32'd0);
        check("rst_ack", 32'(add_ack), 32'd0);
        check("rst_hit", 32'(char_hit), 32'd0);
        rst_n = 1'b1;
        wait_cyc(1);

        // Countdown: decrement every 4 cycles, OVER after 48.
        pulse_start();
        check("run_state", 32'(state), 32'd1);
        check("run_time0", 32'(time_bcd), 32'h12);
        wait_cyc(3);
        check("cd_k3", 32'(time_bcd), 32'h12);
        wait_cyc(1);
        check("cd_k4", 32'(time_bcd), 32'h11);
        wait_cyc(24);
        check("cd_k28_bcd", 32'(time_bcd), 32'h05);
        wait_cyc(19);
        check("cd_k47", 32'(time_bcd), 32'h01);
        check("cd_k47_st", 32'(state), 32'd1);
        wait_cyc(1);
        check("over_time", 32'(time_bcd), 32'h00);
        check("over_state", 32'(state), 32'd4);
        check("over_timeup", 32'(time_up), 32'd1);
        wait_cyc(4);
        check("over_hold", 32'(time_bcd), 32'h00);

        // Add handshake with the request held across the ack cycle.
        pause = 1'b1;
        pulse_start();
        check("restart_score", 32'(score_bcd), 32'h0000);
        add_req = 1'b1;
        add_val = 4'd7;
        wait_cyc(1);
        check("hs_ack1", 32'(add_ack), 32'd1);
        check("hs_score1", 32'(score_bcd), 32'h0007);
        wait_cyc(1);
        check("hs_ack2", 32'(add_ack), 32'd0);
        check("hs_score2", 32'(score_bcd), 32'h0007);
        add_req = 1'b0;
        wait_cyc(1);
        do_add(4'hF);
        check("add_sat_val", 32'(score_bcd), 32'h0016);
        check("paused_time", 32'(time_bcd), 32'h12);

        // Digit lookup of score and time.
        char_xy = 8'h0A;
        wait_cyc(1);
        check("lk_units_code", 32'(char_code), 32'h36);
        check("lk_units_hit", 32'(char_hit), 32'd1);
        char_xy = 8'h1A;
        wait_cyc(1);
        check("lk_ttens", 32'(char_code), 32'h31);
        char_xy = 8'h1B;
        wait_cyc(1);
        check("lk_tunits", 32'(char_code), 32'h32);

        // Add coinciding with level_done, then 12 bonus cycles.
        add_req    = 1'b1;
        add_val    = 4'd3;
        level_done = 1'b1;
        wait_cyc(1);
        add_req    = 1'b0;
        level_done = 1'b0;
        check("ld_state", 32'(state), 32'd2);
        check("ld_add", 32'(score_bcd), 32'h0019);
        check("ld_ack", 32'(add_ack), 32'd1);
        wait_cyc(11);
        check("bn_k11_st", 32'(state), 32'd2);
        check("bn_k11_time", 32'(time_bcd), 32'h01);
        check("bn_k11_score", 32'(score_bcd), 32'h0030);
        wait_cyc(1);
        check("bn_done_st", 32'(state), 32'd3);
        check("bn_done_time", 32'(time_bcd), 32'h00);
        check("bn_done_score", 32'(score_bcd), 32'h0031);

        // Next level keeps the score.
        pause = 1'b0;
        pulse_start();
        check("lvl2_state", 32'(state), 32'd1);
        check("lvl2_score", 32'(score_bcd), 32'h0031);
        check("lvl2_time", 32'(time_bcd), 32'h12);

        // level_done on a tick edge discards the decrement.
        wait_cyc(3);
        level_done = 1'b1;
        wait_cyc(1);
        level_done = 1'b0;
        check("ldtick_state", 32'(state), 32'd2);
        check("ldtick_time", 32'(time_bcd), 32'h12);
        wait_cyc(12);
        check("ldtick_done", 32'(state), 32'd3);
        check("ldtick_score", 32'(score_bcd), 32'h0043);

        // Add on the time-out edge is still counted.
        pulse_start();
        wait_cyc(47);
        check("to_pre", 32'(time_bcd), 32'h01);
        add_req = 1'b1;
        add_val = 4'd2;
        wait_cyc(1);
        add_req = 1'b0;
        check("to_state", 32'(state), 32'd4);
        check("to_score", 32'(score_bcd), 32'h0045);

        // BCD carry.
        pause = 1'b1;
        pulse_start();
        for (int i = 0; i < 11; i++) do_add(4'd9);
        check("carry_99", 32'(score_bcd), 32'h0099);
        do_add(4'd5);
        check("carry_104", 32'(score_bcd), 32'h0104);

        // Asynchronous reset mid-round, away from any clock edge.
        char_xy = 8'h0A;
        wait_cyc(1);
        check("pre_rst_hit", 32'(char_hit), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_score", 32'(score_bcd), 32'h0000);
        check("arst_time", 32'(time_bcd), 32'h00);
        check("arst_code", 32'(char_code), 32'h00);
        check("arst_hit", 32'(char_hit), 32'd0);
        wait_cyc(1);
        rst_n = 1'b1;
        wait_cyc(1);

        // Score 0427 lookup.
        pulse_start();
        for (int i = 0; i < 47; i++) do_add(4'd9);
        do_add(4'd4);
        check("s0427", 32'(score_bcd), 32'h0427);
        char_xy = 8'h09;
        wait_cyc(1);
        check("lk09_code", 32'(char_code), 32'h32);
        check("lk09_hit", 32'(char_hit), 32'd1);
        char_xy = 8'h08;
        wait_cyc(1);
        check("lk08_code", 32'(char_code), 32'h34);
        char_xy = 8'h05;
        wait_cyc(1);
        check("lk05_code", 32'(char_code), 32'h00);
        check("lk05_hit", 32'(char_hit), 32'd0);

        // Saturation: 0427 + 1063*9 + 1 = 9995, then +9 pins at 9999.
        for (int i = 0; i < 1063; i++) do_add(4'd9);
        do_add(4'd1);
        check("s9995", 32'(score_bcd), 32'h9995);
        do_add(4'd9);
        check("sat_9999", 32'(score_bcd), 32'h9999);
        do_add(4'd1);
        check("sat_hold", 32'(score_bcd), 32'h9999);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
